// File: rtl/uart_arb_pkg.sv
// Shared state encoding and one-hot/index helpers for the UART transmit arbiter.
// Build option UART_ARB_WDOG_EN (see uart_tx_arbiter) does not change anything here.
package uart_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } arb_state_e;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester strictly after rr_ptr,
// wrapping modulo NUM_REQ, returned one-hot.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any_valid
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources with burst-locked round-robin.
// Define UART_ARB_WDOG_EN to release an owner that stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WORD_LENGTH  = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [WORD_LENGTH-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic                           arb_abort
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_BURST < 1 || IDLE_TIMEOUT < 2) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    arb_state_e             state, state_n;
    logic [NUM_REQ-1:0]     grant_n;
    logic [WORD_LENGTH-1:0] tx_data_n;
    logic                   tx_start_n;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]       byte_cnt, byte_cnt_n;
    logic                   last_seen, last_seen_n;
    logic [NUM_REQ-1:0]     pick;
    logic                   any_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   accept;

`ifdef UART_ARB_WDOG_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic              arb_abort_q, arb_abort_n;
    assign arb_abort = arb_abort_q;
`else
    assign arb_abort = 1'b0;
`endif

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign grant_idx = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
    assign req_ready = (state == ST_LOCKED && !tx_busy) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            byte_cnt  <= '0;
            last_seen <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            idle_cnt    <= '0;
            arb_abort_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            tx_data   <= tx_data_n;
            tx_start  <= tx_start_n;
            rr_ptr    <= rr_ptr_n;
            byte_cnt  <= byte_cnt_n;
            last_seen <= last_seen_n;
`ifdef UART_ARB_WDOG_EN
            idle_cnt    <= idle_cnt_n;
            arb_abort_q <= arb_abort_n;
`endif
        end
    end

    // Releasing hands rr_ptr the current owner so it queues behind every other valid port.
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        tx_data_n   = tx_data;
        tx_start_n  = 1'b0;
        rr_ptr_n    = rr_ptr;
        byte_cnt_n  = byte_cnt;
        last_seen_n = last_seen;
`ifdef UART_ARB_WDOG_EN
        idle_cnt_n  = idle_cnt;
        arb_abort_n = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!tx_busy && any_valid) begin
                    grant_n    = pick;
                    byte_cnt_n = '0;
                    state_n    = ST_LOCKED;
`ifdef UART_ARB_WDOG_EN
                    idle_cnt_n = '0;
`endif
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    tx_data_n   = req_data[grant_idx*WORD_LENGTH +: WORD_LENGTH];
                    tx_start_n  = 1'b1;
                    byte_cnt_n  = byte_cnt + 1'b1;
                    last_seen_n = req_last[grant_idx];
                    state_n     = ST_WAIT_ACK;
`ifdef UART_ARB_WDOG_EN
                    idle_cnt_n  = '0;
                end else if (!req_valid[grant_idx]) begin
                    if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        rr_ptr_n    = grant_idx;
                        grant_n     = '0;
                        state_n     = ST_IDLE;
                        arb_abort_n = 1'b1;
                        idle_cnt_n  = '0;
                    end else begin
                        idle_cnt_n = idle_cnt + 1'b1;
                    end
`endif
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_seen || byte_cnt == CNT_W'(MAX_BURST)) begin
                        rr_ptr_n = grant_idx;
                        grant_n  = '0;
                        state_n  = ST_IDLE;
                    end else begin
                        state_n = ST_LOCKED;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-port byte queues, a UART busy model and a frame log
// compared against hand-written expected frame lists ({grant, byte} per tx_start).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WL      = 8;

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ*WL-1:0] req_data = '0;
    logic [NUM_REQ-1:0] req_last  = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] grant;
    logic [WL-1:0]      tx_data;
    logic               tx_start;
    logic               tx_busy   = 1'b0;
    logic               arb_abort;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WORD_LENGTH  (WL),
        .MAX_BURST    (16),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .arb_abort (arb_abort)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [8:0]   port_q [NUM_REQ][$];
    logic [11:0]  frames[$];
    logic [11:0]  exp_frames[$];
    int           fall_ticks[$];
    logic [NUM_REQ-1:0] acc_mask = '0;
    logic         busy_pending = 1'b0;
    int           busy_left    = 0;
    int           busy_dur     = 6;
    bit           rand_busy    = 1'b0;
    logic         prev_start   = 1'b0;
    logic [WL-1:0] cur_byte    = '0;
    logic         data_stable  = 1'b1;
    bit           check_stable = 1'b1;
    int           abort_cnt    = 0;
    int           abort_tick   = 0;
    logic [NUM_REQ-1:0] abort_grant = '0;
    int           tick_no      = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit allEmpty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (port_q[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: retire accepted bytes, log frames, step the UART busy model, drive requesters.
    task automatic applyStimulus();
        logic [8:0] head;
        @(negedge clk);
        tick_no++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_mask[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
        end
        if (tx_start) begin
            checkOutput("start_legal", {29'd0, tx_busy, busy_pending, prev_start}, 32'd0);
            frames.push_back({grant, tx_data});
            cur_byte    = tx_data;
            data_stable = 1'b1;
        end
        if (tx_busy && tx_data !== cur_byte) data_stable = 1'b0;
        prev_start = tx_start;
        if (arb_abort) begin
            abort_cnt++;
            abort_tick  = tick_no;
            abort_grant = grant;
        end
        if (busy_pending) begin
            tx_busy      = 1'b1;
            busy_left    = rand_busy ? int'($urandom_range(200, 1)) : busy_dur;
            busy_pending = 1'b0;
        end else if (tx_busy) begin
            busy_left--;
            if (busy_left <= 0) begin
                tx_busy = 1'b0;
                fall_ticks.push_back(tick_no);
                if (check_stable) checkOutput("tx_data_stable", {31'd0, data_stable}, 32'd1);
            end
        end
        if (tx_start) busy_pending = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            head = (port_q[i].size() > 0) ? port_q[i][0] : 9'd0;
            req_valid[i]          = port_q[i].size() > 0;
            req_data[i*WL +: WL]  = head[7:0];
            req_last[i]           = head[8];
        end
        #1;
        acc_mask = reset ? (req_valid & req_ready) : '0;
    endtask

    task automatic runUntilDrained(input int limit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            applyStimulus();
            n++;
            done = allEmpty() && !tx_busy && !busy_pending;
        end
        checkOutput("drained", {31'd0, done}, 32'd1);
        repeat (3) applyStimulus();
    endtask

    task automatic compareFrames(input string tag);
        checkOutput({tag, "_count"}, 32'(frames.size()), 32'(exp_frames.size()));
        for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
            checkOutput($sformatf("%s_frame%0d", tag, i), 32'(frames[i]), 32'(exp_frames[i]));
        end
    endtask

    task automatic resetDut();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) port_q[i].delete();
        repeat (2) applyStimulus();
        reset = 1'b1;
        frames.delete();
        exp_frames.delete();
        fall_ticks.delete();
    endtask

    initial begin
        resetDut();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_arb_abort", 32'(arb_abort), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

        $display("[TB] test 1: single port burst");
        port_q[2].push_back({1'b0, 8'hA1});
        port_q[2].push_back({1'b0, 8'hA2});
        port_q[2].push_back({1'b1, 8'hA3});
        applyStimulus();
        applyStimulus();
        checkOutput("t1_lat_grant", 32'(grant), 32'h4);
        checkOutput("t1_lat_ready", 32'(req_ready), 32'h4);
        applyStimulus();
        checkOutput("t1_lat_start", 32'(tx_start), 32'd1);
        runUntilDrained(500);
        exp_frames = {12'h4A1, 12'h4A2, 12'h4A3};
        compareFrames("t1");
        checkOutput("t1_grant_end", 32'(grant), 32'd0);

        $display("[TB] test 2: all ports, one byte each");
        resetDut();
        port_q[0].push_back({1'b1, 8'h10});
        port_q[0].push_back({1'b1, 8'h14});
        port_q[1].push_back({1'b1, 8'h11});
        port_q[2].push_back({1'b1, 8'h12});
        port_q[3].push_back({1'b1, 8'h13});
        runUntilDrained(1000);
        exp_frames = {12'h110, 12'h211, 12'h412, 12'h813, 12'h114};
        compareFrames("t2");

        $display("[TB] test 3: burst limit");
        resetDut();
        for (int i = 0; i < 20; i++) port_q[1].push_back({1'b0, 8'(8'h20 + i)});
        port_q[3].push_back({1'b1, 8'h77});
        runUntilDrained(3000);
        for (int i = 0; i < 16; i++) exp_frames.push_back({4'h2, 8'(8'h20 + i)});
        exp_frames.push_back(12'h877);
        for (int i = 16; i < 20; i++) exp_frames.push_back({4'h2, 8'(8'h20 + i)});
        compareFrames("t3");
`ifndef UART_ARB_WDOG_EN
        checkOutput("t3_grant_held", 32'(grant), 32'h2);
        checkOutput("t3_ready_held", 32'(req_ready), 32'h2);
`endif

        $display("[TB] test 4: reset during frame");
        resetDut();
        busy_dur = 20;
        port_q[0].push_back({1'b1, 8'h5A});
        for (int n = 0; n < 20 && !tx_busy; n++) applyStimulus();
        checkOutput("t4_busy_seen", 32'(tx_busy), 32'd1);
        applyStimulus();
        applyStimulus();
        port_q[1].push_back({1'b1, 8'h66});
        check_stable = 1'b0;
        frames.delete();
        reset = 1'b0;
        applyStimulus();
        checkOutput("t4_rst_grant", 32'(grant), 32'd0);
        checkOutput("t4_rst_start", 32'(tx_start), 32'd0);
        reset = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("t4_no_grant_busy", 32'(grant), 32'd0);
        runUntilDrained(200);
        exp_frames = {12'h266};
        compareFrames("t4");
        check_stable = 1'b1;
        busy_dur = 6;

`ifdef UART_ARB_WDOG_EN
        $display("[TB] test 5: idle watchdog");
        resetDut();
        abort_cnt = 0;
        busy_dur  = 5;
        port_q[0].push_back({1'b0, 8'h55});
        port_q[1].push_back({1'b1, 8'h99});
        runUntilDrained(300);
        exp_frames = {12'h155, 12'h299};
        compareFrames("t5");
        checkOutput("t5_abort_cnt", 32'(abort_cnt), 32'd1);
        // busy fall is seen by the DUT one edge later, then 8 idle LOCKED cycles
        checkOutput("t5_abort_delay", 32'(abort_tick - fall_ticks[0]), 32'd9);
        checkOutput("t5_abort_grant", 32'(abort_grant), 32'd0);
        busy_dur = 6;
`endif

        $display("[TB] test 6: random busy lengths");
        resetDut();
        rand_busy = 1'b1;
        port_q[0].push_back({1'b1, 8'hC0});
        port_q[0].push_back({1'b1, 8'hC1});
        port_q[0].push_back({1'b1, 8'hC2});
        port_q[3].push_back({1'b1, 8'hD0});
        port_q[3].push_back({1'b1, 8'hD1});
        port_q[3].push_back({1'b1, 8'hD2});
        runUntilDrained(3000);
        exp_frames = {12'h1C0, 12'h8D0, 12'h1C1, 12'h8D1, 12'h1C2, 12'h8D2};
        compareFrames("t6");
        rand_busy = 1'b0;

`ifndef UART_ARB_WDOG_EN
        checkOutput("no_abort", 32'(abort_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
